// File: rtl/perf_counter_bank_pkg.sv
// Shared address map, control-bit positions and decode helper for the
// performance counter bank.
package perf_counter_bank_pkg;

    // Word-aligned register addresses; counter i lives at cnt_base + 4*i.
    typedef enum logic [7:0] {
        cnt_base    = 8'h00,
        perf_status = 8'hF8,
        perf_ctrl   = 8'hFC
    } counter_addr;

    localparam int PERF_CTRL_FREEZE = 0;
    localparam int PERF_CTRL_CLEAR  = 1;

    // True when two byte addresses fall in the same 32-bit word.
    function automatic logic addr_hit(input logic [7:0] addr, input logic [7:0] target);
        return (addr & 8'hFC) == (target & 8'hFC);
    endfunction

endpackage

// File: rtl/perf_counter.sv
// One performance counter: increment adder, wrap/saturate handling,
// clear/load/freeze priority and overflow detection.
module perf_counter #(
    parameter int CNT_WIDTH = 32,
    parameter int INC_WIDTH = 1,
    parameter int SATURATE  = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clear_i,
    input  logic                 load_i,
    input  logic [CNT_WIDTH-1:0] load_val_i,
    input  logic                 freeze_i,
    input  logic [INC_WIDTH-1:0] inc_i,
    output logic [CNT_WIDTH-1:0] count,
    output logic                 ovf_event
);

    // Adder is wide enough for the carry even when the increment is wider
    // than the counter itself.
    localparam int SUM_W = (CNT_WIDTH >= INC_WIDTH) ? CNT_WIDTH + 1 : INC_WIDTH + 1;

    logic [CNT_WIDTH-1:0] cnt_q;
    logic [CNT_WIDTH-1:0] cnt_d;
    logic [SUM_W-1:0]     sum_s;
    logic                 carry_s;

    // Next count: clear beats load beats freeze beats accumulate.
    always_comb begin
        sum_s     = SUM_W'(cnt_q) + SUM_W'(inc_i);
        carry_s   = |sum_s[SUM_W-1:CNT_WIDTH];
        cnt_d     = cnt_q;
        ovf_event = 1'b0;
        if (clear_i) begin
            cnt_d = {CNT_WIDTH{1'b0}};
        end else if (load_i) begin
            cnt_d = load_val_i;
        end else if (freeze_i) begin
            cnt_d = cnt_q;
        end else if (carry_s) begin
            ovf_event = 1'b1;
            if (SATURATE != 0) begin
                cnt_d = {CNT_WIDTH{1'b1}};
            end else begin
                cnt_d = sum_s[CNT_WIDTH-1:0];
            end
        end else begin
            cnt_d = sum_s[CNT_WIDTH-1:0];
        end
    end

    // Counter state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= {CNT_WIDTH{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign count = cnt_q;

endmodule

// File: rtl/perf_counter_bank.sv
// Memory-mapped bank of performance counters with sticky overflow flags,
// global freeze and global clear. Reads and writes answer one cycle later.
module perf_counter_bank
    import perf_counter_bank_pkg::*;
#(
    parameter int NUM_CNT   = 11,
    parameter int CNT_WIDTH = 32,
    parameter int INC_WIDTH = 1,
    parameter int SATURATE  = 0
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_CNT*INC_WIDTH-1:0] event_inc,
    input  logic                         mem_read,
    input  logic                         mem_write,
    input  logic [7:0]                   mem_address,
    input  logic [31:0]                  mem_wdata,
    output logic [31:0]                  mem_rdata,
    output logic                         mem_resp
);

    logic [CNT_WIDTH-1:0] count_s [NUM_CNT];
    logic [NUM_CNT-1:0]   ovf_evt_s;
    logic [NUM_CNT-1:0]   load_s;
    logic [NUM_CNT-1:0]   ovf_q;
    logic [NUM_CNT-1:0]   ovf_d;
    logic                 freeze_q;
    logic                 freeze_d;
    logic                 resp_q;
    logic                 resp_d;
    logic [31:0]          rdata_q;
    logic [31:0]          rdata_d;
    logic                 rd_s;
    logic                 status_wr_s;
    logic                 ctrl_wr_s;
    logic                 clear_all_s;
    logic                 unused_s;

    // Not every write-data bit reaches a register for every parameter set.
    assign unused_s = ^mem_wdata;

    // Address decode; a simultaneous read and write is treated as a write.
    always_comb begin
        rd_s        = mem_read & ~mem_write;
        status_wr_s = mem_write & addr_hit(mem_address, perf_status);
        ctrl_wr_s   = mem_write & addr_hit(mem_address, perf_ctrl);
        clear_all_s = ctrl_wr_s & mem_wdata[PERF_CTRL_CLEAR];
        for (int i = 0; i < NUM_CNT; i++) begin
            load_s[i] = mem_write & addr_hit(mem_address, 8'(4 * i));
        end
    end

    for (genvar g = 0; g < NUM_CNT; g++) begin : g_cnt
        perf_counter #(
            .CNT_WIDTH (CNT_WIDTH),
            .INC_WIDTH (INC_WIDTH),
            .SATURATE  (SATURATE)
        ) u_cnt (
            .clk        (clk),
            .rst_n      (rst_n),
            .clear_i    (clear_all_s),
            .load_i     (load_s[g]),
            .load_val_i (mem_wdata[CNT_WIDTH-1:0]),
            .freeze_i   (freeze_q),
            .inc_i      (event_inc[g*INC_WIDTH +: INC_WIDTH]),
            .count      (count_s[g]),
            .ovf_event  (ovf_evt_s[g])
        );
    end

    // Sticky flags (set wins over write-1-to-clear) and freeze control.
    always_comb begin
        if (clear_all_s) begin
            ovf_d = {NUM_CNT{1'b0}};
        end else if (status_wr_s) begin
            ovf_d = (ovf_q & ~mem_wdata[NUM_CNT-1:0]) | ovf_evt_s;
        end else begin
            ovf_d = ovf_q | ovf_evt_s;
        end
        if (ctrl_wr_s) begin
            freeze_d = mem_wdata[PERF_CTRL_FREEZE];
        end else begin
            freeze_d = freeze_q;
        end
    end

    // Response data, taken from the state before this edge's update.
    always_comb begin
        resp_d  = mem_read | mem_write;
        rdata_d = 32'h0;
        if (!rd_s) begin
            rdata_d = 32'h0;
        end else if (addr_hit(mem_address, perf_status)) begin
            rdata_d = 32'(ovf_q);
        end else if (addr_hit(mem_address, perf_ctrl)) begin
            rdata_d = {31'h0, freeze_q};
        end else begin
            for (int i = 0; i < NUM_CNT; i++) begin
                if (addr_hit(mem_address, 8'(4 * i))) begin
                    rdata_d = 32'(count_s[i]);
                end else begin
                    rdata_d = rdata_d;
                end
            end
        end
    end

    // Status, control and response registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q    <= {NUM_CNT{1'b0}};
            freeze_q <= 1'b0;
            resp_q   <= 1'b0;
            rdata_q  <= 32'h0;
        end else begin
            ovf_q    <= ovf_d;
            freeze_q <= freeze_d;
            resp_q   <= resp_d;
            rdata_q  <= rdata_d;
        end
    end

    assign mem_resp  = resp_q;
    assign mem_rdata = rdata_q;

endmodule

// File: tb/tb_perf_counter_bank.sv
// Scoreboard bench: a wrapping and a saturating bank share one bus and one
// event stream; a reference model predicts each response into per-DUT queues
// that independent monitors drain.
module tb_perf_counter_bank;

    localparam int NC  = 11;
    localparam int CW  = 8;
    localparam int IW  = 2;
    localparam int IWT = NC * IW;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [IWT-1:0] event_inc = '0;
    logic           mem_read = 1'b0;
    logic           mem_write = 1'b0;
    logic [7:0]     mem_address = 8'h00;
    logic [31:0]    mem_wdata = 32'h0;
    logic [31:0]    rdata_w, rdata_s;
    logic           resp_w, resp_s;

    perf_counter_bank #(.NUM_CNT(NC), .CNT_WIDTH(CW), .INC_WIDTH(IW), .SATURATE(0)) dut_w (
        .clk(clk), .rst_n(rst_n), .event_inc(event_inc), .mem_read(mem_read),
        .mem_write(mem_write), .mem_address(mem_address), .mem_wdata(mem_wdata),
        .mem_rdata(rdata_w), .mem_resp(resp_w));

    perf_counter_bank #(.NUM_CNT(NC), .CNT_WIDTH(CW), .INC_WIDTH(IW), .SATURATE(1)) dut_s (
        .clk(clk), .rst_n(rst_n), .event_inc(event_inc), .mem_read(mem_read),
        .mem_write(mem_write), .mem_address(mem_address), .mem_wdata(mem_wdata),
        .mem_rdata(rdata_s), .mem_resp(resp_s));

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int unsigned due;
        logic [31:0] data;
    } exp_t;

    exp_t q_w[$];
    exp_t q_s[$];
    int   n_cmp = 0;
    int   n_fail = 0;

    // Reference model: index 0 wraps, index 1 saturates.
    int unsigned mcnt [2][NC];
    bit          movf [2][NC];
    bit          mfrz [2];

    function automatic void chk(string nm, logic [31:0] got, logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endfunction

    function automatic void model_reset();
        for (int m = 0; m < 2; m++) begin
            mfrz[m] = 1'b0;
            for (int i = 0; i < NC; i++) begin
                mcnt[m][i] = 0;
                movf[m][i] = 1'b0;
            end
        end
    endfunction

    function automatic logic [31:0] model_read(int m, logic [7:0] a);
        int wa = int'(a) & 252;
        logic [31:0] r = 32'h0;
        if (wa / 4 < NC) r = mcnt[m][wa / 4];
        else if (wa == 248) for (int i = 0; i < NC; i++) r[i] = movf[m][i];
        else if (wa == 252) r[0] = mfrz[m];
        return r;
    endfunction

    function automatic void model_update(int m, bit wr, logic [7:0] a, logic [31:0] wd,
                                         logic [IWT-1:0] inc);
        int wa = wr ? (int'(a) & 252) : -1;
        bit old_frz = mfrz[m];
        int unsigned s;
        if (wa == 252) mfrz[m] = wd[0];
        if (wa == 252 && wd[1]) begin
            for (int i = 0; i < NC; i++) begin
                mcnt[m][i] = 0;
                movf[m][i] = 1'b0;
            end
            return;
        end
        if (wa == 248) for (int i = 0; i < NC; i++) if (wd[i]) movf[m][i] = 1'b0;
        for (int i = 0; i < NC; i++) begin
            if (wa == 4 * i) begin
                mcnt[m][i] = wd & 32'hFF;
            end else if (!old_frz) begin
                s = mcnt[m][i] + int'(inc[i*IW +: IW]);
                if (s > 255) begin
                    movf[m][i] = 1'b1;
                    mcnt[m][i] = (m == 1) ? 255 : s - 256;
                end else begin
                    mcnt[m][i] = s;
                end
            end
        end
    endfunction

    function automatic logic [IWT-1:0] one_inc(int i, logic [1:0] v);
        logic [IWT-1:0] r = '0;
        r[i*IW +: IW] = v;
        return r;
    endfunction

    function automatic logic [IWT-1:0] all_inc(logic [1:0] v);
        return {NC{v}};
    endfunction

    // One bus cycle: drive, predict, advance the model, then cross the edge.
    task automatic step(bit rd, bit wr, logic [7:0] a, logic [31:0] wd, logic [IWT-1:0] inc);
        exp_t e;
        mem_read = rd;
        mem_write = wr;
        mem_address = a;
        mem_wdata = wd;
        event_inc = inc;
        if (rd || wr) begin
            e.due = cyc + 1;
            e.data = (rd && !wr) ? model_read(0, a) : 32'h0;
            q_w.push_back(e);
            e.data = (rd && !wr) ? model_read(1, a) : 32'h0;
            q_s.push_back(e);
        end
        model_update(0, wr, a, wd, inc);
        model_update(1, wr, a, wd, inc);
        @(posedge clk);
        #1;
    endtask

    task automatic rd_at(logic [7:0] a);
        step(1'b1, 1'b0, a, 32'h0, '0);
    endtask

    task automatic wr_at(logic [7:0] a, logic [31:0] wd, logic [IWT-1:0] inc);
        step(1'b0, 1'b1, a, wd, inc);
    endtask

    // Judge one port at one sample point; returns 1 when the head entry is consumed.
    function automatic bit judge(string nm, bit have, exp_t f, logic resp, logic [31:0] rd);
        bit due_now = have && (f.due == cyc);
        n_cmp++;
        if (resp) begin
            if (!due_now) begin
                n_fail++;
                $display("FAIL %s unexpected_resp at cycle %0d: got rdata %h, no response was due",
                         nm, cyc, rd);
                return have && (f.due < cyc);
            end
            if (rd !== f.data) begin
                n_fail++;
                $display("FAIL %s rdata at cycle %0d: got %h expected %h", nm, cyc, rd, f.data);
            end
            return 1'b1;
        end
        if (due_now) begin
            n_fail++;
            $display("FAIL %s missing_resp at cycle %0d: got resp 0 expected 1 (data %h)",
                     nm, cyc, f.data);
        end else if (rd !== 32'h0) begin
            n_fail++;
            $display("FAIL %s idle_rdata at cycle %0d: got %h expected 00000000", nm, cyc, rd);
        end
        return due_now;
    endfunction

    // Monitors sample on the falling edge, away from the active edge.
    always @(negedge clk) begin
        exp_t f;
        if (rst_n) begin
            f.due = 0;
            f.data = 32'h0;
            if (q_w.size() > 0) f = q_w[0];
            if (judge("wrap", q_w.size() > 0, f, resp_w, rdata_w)) void'(q_w.pop_front());
            f.due = 0;
            f.data = 32'h0;
            if (q_s.size() > 0) f = q_s[0];
            if (judge("sat", q_s.size() > 0, f, resp_s, rdata_s)) void'(q_s.pop_front());
        end
    end

    function automatic logic [7:0] rand_addr();
        int k = $urandom_range(0, 15);
        if (k < NC) return 8'(4 * k + $urandom_range(0, 3));
        if (k == 11) return 8'hF8;
        if (k == 12) return 8'hFC;
        return 8'($urandom_range(0, 255));
    endfunction

    initial begin
        int r;
        model_reset();

        // Reset values.
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_resp_w", 32'(resp_w), 32'h0);
        chk("reset_rdata_w", rdata_w, 32'h0);
        chk("reset_resp_s", 32'(resp_s), 32'h0);
        chk("reset_rdata_s", rdata_s, 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Reset mid-count with a read in flight: the read must vanish.
        repeat (3) step(1'b0, 1'b0, 8'h00, 32'h0, all_inc(2'd1));
        mem_read = 1'b1;
        mem_address = 8'h00;
        event_inc = all_inc(2'd1);
        #2;
        rst_n = 1'b0;
        model_reset();
        q_w.delete();
        q_s.delete();
        mem_read = 1'b0;
        event_inc = '0;
        @(negedge clk);
        chk("midreset_resp_w", 32'(resp_w), 32'h0);
        chk("midreset_rdata_s", rdata_s, 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (2) step(1'b0, 1'b0, 8'h00, 32'h0, '0);

        // Basic count on counter 0, then read every counter back to back.
        repeat (5) step(1'b0, 1'b0, 8'h00, 32'h0, one_inc(0, 2'd1));
        for (int i = 0; i < NC; i++) rd_at(8'(4 * i));

        // Wrap / saturate across the top of counter 2, then W1C its flag.
        wr_at(8'h08, 32'hFE, '0);
        repeat (3) step(1'b0, 1'b0, 8'h00, 32'h0, one_inc(2, 2'd1));
        rd_at(8'h08);
        rd_at(8'hF8);
        wr_at(8'hF8, 32'h4, '0);
        rd_at(8'hF8);

        // Large increments on counter 3.
        wr_at(8'h0C, 32'hFD, '0);
        repeat (2) step(1'b0, 1'b0, 8'h00, 32'h0, one_inc(3, 2'd3));
        rd_at(8'h0C);
        rd_at(8'hF8);

        // Load beats increment; clear_all beats everything.
        wr_at(8'h04, 32'h10, one_inc(1, 2'd1));
        rd_at(8'h04);
        wr_at(8'hFC, 32'h2, all_inc(2'd3));
        for (int i = 0; i < NC; i++) rd_at(8'(4 * i));
        rd_at(8'hF8);
        rd_at(8'hFC);

        // Freeze: the freezing cycle's increment still counts.
        wr_at(8'hFC, 32'h1, all_inc(2'd1));
        repeat (10) step(1'b0, 1'b0, 8'h00, 32'h0, IWT'($urandom));
        rd_at(8'hFC);
        wr_at(8'hFC, 32'h0, all_inc(2'd2));
        repeat (3) step(1'b0, 1'b0, 8'h00, 32'h0, all_inc(2'd1));
        for (int i = 0; i < NC; i++) rd_at(8'(4 * i));
        rd_at(8'hFC);

        // Bus corners: unmapped, low address bits, read+write together.
        rd_at(8'h80);
        rd_at(8'h05);
        step(1'b1, 1'b1, 8'h14, 32'h33, '0);
        rd_at(8'h14);

        // Randomized traffic with overlapping events.
        for (int n = 0; n < 600; n++) begin
            r = $urandom_range(0, 9);
            case (r)
                0, 1, 2: step(1'b1, 1'b0, rand_addr(), 32'h0, IWT'($urandom));
                3: step(1'b0, 1'b1, 8'(4 * $urandom_range(0, NC - 1)), $urandom, IWT'($urandom));
                4: step(1'b0, 1'b1, 8'hF8, $urandom, IWT'($urandom));
                5: step(1'b0, 1'b1, 8'hFC,
                        {30'h0, 1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 3) == 0)},
                        IWT'($urandom));
                6: step(1'b1, 1'b1, rand_addr(), $urandom, IWT'($urandom));
                default: step(1'b0, 1'b0, 8'h00, 32'h0, IWT'($urandom));
            endcase
        end
        for (int i = 0; i < NC; i++) rd_at(8'(4 * i));
        rd_at(8'hF8);

        // Drain and confirm every predicted response was seen.
        repeat (3) step(1'b0, 1'b0, 8'h00, 32'h0, '0);
        chk("drain_queues", 32'(q_w.size() + q_s.size()), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
